// File: rtl/fft_pkg.sv
// Shared sizes, FSM state type and the 32-point Hann window coefficients
// used by the FFT sample loader.
package fft_pkg;

  localparam int FFT_N      = 32;
  localparam int FFT_ADDR_W = 5;
  localparam int FFT_DATA_W = 16;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } loader_state_t;

  // w[n] = round(32767 * 0.5 * (1 - cos(2*pi*n/31))), symmetric about 15.5
  localparam logic [FFT_DATA_W-1:0] HANN_TABLE [FFT_N] = '{
    16'h0000, 16'h014F, 16'h0530, 16'h0B79, 16'h13E8, 16'h1E25, 16'h29C5, 16'h364F,
    16'h433D, 16'h500A, 16'h5C2F, 16'h672C, 16'h708F, 16'h77F4, 16'h7D10, 16'h7FAB,
    16'h7FAB, 16'h7D10, 16'h77F4, 16'h708F, 16'h672C, 16'h5C2F, 16'h500A, 16'h433D,
    16'h364F, 16'h29C5, 16'h1E25, 16'h13E8, 16'h0B79, 16'h0530, 16'h014F, 16'h0000
  };

endpackage

// File: rtl/fft_window_rom.sv
// Combinational Hann coefficient lookup: index in, Q1.15 window weight out.
module fft_window_rom
  import fft_pkg::*;
(
  input  logic [FFT_ADDR_W-1:0] index,
  output logic [FFT_DATA_W-1:0] coef
);

  assign coef = HANN_TABLE[index];

endmodule

// File: rtl/fft_sample_loader.sv
// Streams 32 real samples into the FFT data memory (optionally Hann windowed),
// launches the transform, then waits for a fresh FFT_done edge before refilling.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int WINDOW_EN   = 1,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   ACLR_n,
  input  logic                   sample_valid,
  input  logic [FFT_DATA_W-1:0]  sample_in,
  output logic                   sample_ready,
  input  logic                   FFT_done,
  output logic [FFT_ADDR_W-1:0]  LoadDataAddr,
  output logic [FFT_DATA_W-1:0]  data_real_in,
  output logic [FFT_DATA_W-1:0]  data_imag_in,
  output logic                   LoadDataWrite,
  output logic                   start_FFT,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic signed [2*FFT_DATA_W-1:0] ROUND_HALF = 32'sd16384;
  localparam logic signed [2*FFT_DATA_W-1:0] SAT_MAX    = 32'sd32767;
  localparam logic signed [2*FFT_DATA_W-1:0] SAT_MIN    = -32'sd32768;
  localparam logic [FFT_ADDR_W-1:0]          LAST_IDX   = FFT_ADDR_W'(FFT_N - 1);

  loader_state_t state, state_next;

  logic [FFT_ADDR_W-1:0] sample_idx;
  logic                  ready_en;
  logic                  done_q;
  logic                  done_rise;
  logic                  last_pending;
  logic                  accept;

  logic [FFT_DATA_W-1:0]          win_coef;
  logic signed [2*FFT_DATA_W-1:0] product;
  logic signed [2*FFT_DATA_W-1:0] rounded;
  logic [FFT_DATA_W-1:0]          windowed;
  logic [FFT_DATA_W-1:0]          load_value;

  fft_window_rom u_window_rom (
    .index (sample_idx),
    .coef  (win_coef)
  );

  // Q1.15 x Q1.15 multiply, round half up, drop 15 fraction bits, saturate.
  always_comb begin
    product  = $signed({{FFT_DATA_W{sample_in[FFT_DATA_W-1]}}, sample_in})
             * $signed({{FFT_DATA_W{win_coef[FFT_DATA_W-1]}}, win_coef});
    rounded  = (product + ROUND_HALF) >>> 15;
    if (rounded > SAT_MAX) begin
      windowed = SAT_MAX[FFT_DATA_W-1:0];
    end else if (rounded < SAT_MIN) begin
      windowed = SAT_MIN[FFT_DATA_W-1:0];
    end else begin
      windowed = rounded[FFT_DATA_W-1:0];
    end
  end

  assign load_value = (WINDOW_EN != 0) ? windowed : sample_in;

  // The write of index 31 is still on the bus for one cycle after its
  // acceptance; the FSM leaves FILL only once that write has been issued so
  // start_FFT lands strictly after the last memory write.
  assign last_pending = LoadDataWrite && (LoadDataAddr == LAST_IDX);
  assign done_rise    = FFT_done && !done_q;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    sample_ready = 1'b0;
    unique case (state)
      FILL: begin
        sample_ready = ready_en && !last_pending;
        if (last_pending) state_next = START;
      end
      START:     state_next = WAIT_DONE;
      WAIT_DONE: if (done_rise) state_next = FILL;
      default:   state_next = FILL;
    endcase
  end

  assign accept = sample_valid && sample_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge ACLR_n) begin
    if (!ACLR_n) begin
      state         <= FILL;
      ready_en      <= 1'b0;
      done_q        <= 1'b0;
      sample_idx    <= '0;
      frame_count   <= '0;
      LoadDataWrite <= 1'b0;
      LoadDataAddr  <= '0;
      data_real_in  <= '0;
      start_FFT     <= 1'b0;
    end else begin
      state         <= state_next;
      ready_en      <= 1'b1;
      done_q        <= FFT_done;
      start_FFT     <= (state_next == START);
      LoadDataWrite <= accept;
      if (accept) begin
        sample_idx   <= sample_idx + FFT_ADDR_W'(1);
        LoadDataAddr <= sample_idx;
        data_real_in <= load_value;
      end
      if (state == START) frame_count <= frame_count + FRAME_CNT_W'(1);
    end
  end

  assign data_imag_in = '0;

endmodule

// File: doc/fft_sample_loader.md
FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

Interface
REQ-001 SHALL have parameter WINDOW_EN, default 1, meaning 1 = apply Hann window to each sample, 0 = pass samples through unchanged.
REQ-002 SHALL have parameter FRAME_CNT_W, default 8, meaning width of frame_count.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port ACLR_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port sample_valid, input, 1, meaning sample_in holds a valid sample.
REQ-006 SHALL have port sample_in, input, 16, meaning signed Q1.15 real time-domain sample.
REQ-007 SHALL have port sample_ready, output, 1, meaning the loader accepts a sample this cycle.
REQ-008 SHALL have port FFT_done, input, 1, meaning the FFT core's completion flag.
REQ-009 SHALL have port LoadDataAddr, output, 5, meaning the natural-order sample index; the FFT core performs the bit reversal.
REQ-010 SHALL have port data_real_in, output, 16, meaning the windowed sample.
REQ-011 SHALL have port data_imag_in, output, 16, meaning the imaginary part, always 16'h0000.
REQ-012 SHALL have port LoadDataWrite, output, 1, meaning write strobe into FFT data memory.
REQ-013 SHALL have port start_FFT, output, 1, meaning one-cycle pulse that launches the transform.
REQ-014 SHALL have port frame_count, output, FRAME_CNT_W, meaning the number of frames handed to the FFT, wrapping.

Function
REQ-015 SHALL implement states FILL, START and WAIT_DONE.
REQ-016 A sample SHALL be accepted when sample_valid and sample_ready are both 1; sample_ready SHALL be 1 only in FILL.
REQ-017 Accepted sample index n (0..31) SHALL produce LoadDataWrite=1, LoadDataAddr=n and data_real_in=windowed value in the following cycle (latency 1); LoadDataWrite SHALL be 0 in every other cycle.
REQ-018 Windowed value SHALL be computed as follows: 32-bit signed product sample_in*w[n], add 2^14, arithmetic shift right 15, then saturate to [-32768, 32767].
REQ-019 With WINDOW_EN=0, data_real_in SHALL equal sample_in exactly, with the same latency.
REQ-020 Sample counter SHALL wrap 31->0; acceptance of index 31 SHALL move FILL->START.
REQ-021 START SHALL last exactly one cycle; start_FFT SHALL be 1 in that cycle, which is the cycle after the LoadDataWrite for index 31; START->WAIT_DONE.
REQ-022 frame_count SHALL increment by 1 in the START cycle, wrapping at 2^FRAME_CNT_W.
REQ-023 WAIT_DONE->FILL SHALL occur only on a registered 0->1 edge of FFT_done; a level of FFT_done already high on entry SHALL be ignored until it falls and rises again.
REQ-024 sample_valid during START or WAIT_DONE SHALL be ignored, with no sample consumed or lost upstream, because sample_ready is 0.
REQ-025 An FFT_done edge occurring in FILL or START SHALL have no effect.

Reset
REQ-026 ACLR_n=0 SHALL immediately clear to: state FILL, sample counter 0, frame_count 0, LoadDataWrite 0, start_FFT 0, LoadDataAddr 0, data_real_in 0, data_imag_in 0, FFT_done edge register 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release, the first accepted sample SHALL be index 0.
REQ-028 sample_ready SHALL be 0 while ACLR_n=0 and SHALL be 1 from the first clock edge after release.

Structure
REQ-029 Package fft_pkg SHALL hold FFT_N=32, FFT_ADDR_W=5, FFT_DATA_W=16 and the 32-entry Hann table w[n]=round(32767*0.5*(1-cos(2*pi*n/31))) with w[0]=w[31]=16'h0000 and w[15]=w[16]=16'h7FAB.
REQ-030 Sub-module fft_window_rom SHALL be combinational, taking a 5-bit index and returning w[index]; the multiply/round/saturate logic and the FSM SHALL reside in fft_sample_loader.

Verification
REQ-031 WINDOW_EN=0, 32 back-to-back samples with values 0..31 -> 32 consecutive LoadDataWrite pulses with addr=data=n, start_FFT high once in the next cycle, frame_count=1.
REQ-032 WINDOW_EN=1, all samples 16'h7FFF -> data_real_in 16'h0000 at n=0 and n=31, and 16'h7FAA at n=15 ((32767*32683+16384)>>15 = 32682).
REQ-033 All samples 16'h8000 with WINDOW_EN=1 -> n=15 output 16'h8055; no output exceeds the saturation bounds.
REQ-034 sample_valid held high through WAIT_DONE with FFT_done held 1 from entry -> no acceptance; FFT_done 1->0->1 -> sample_ready=1 in the next cycle.
REQ-035 ACLR_n pulsed low after 10 accepted samples -> all outputs 0 immediately; the next accepted sample writes LoadDataAddr=0.
REQ-036 Gapped sample_valid (1 of every 3 cycles) across 257 frames -> 32 writes per frame in address order, and frame_count wraps to 1.
